// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port of the MEM stage: the stage is the master, memory the slave.
interface mem_access_stage_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_wstrb;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: EX/MEM and MEM/WB registers, byte/half/word access over a req/ack port.
// Optional MISALIGN_TRAP_EN: misaligned accesses fault instead of being force-aligned.
module mem_access_stage #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               e_valid,
  input  logic [31:0]        e_ALURes,
  input  logic [31:0]        e_B_bypass_data,
  input  logic               e_MemRd,
  input  logic               e_MemWr,
  input  logic [2:0]         e_funct3,
  input  logic [4:0]         e_rd,
  input  logic               e_RegWEn,
  output logic               stall,
  output logic               m_valid,
  output logic [31:0]        m_ALURes,
  output logic [4:0]         m_rd,
  output logic               m_RegWEn,
  mem_access_stage_if.master dmem,
  output logic               wb_valid,
  output logic [31:0]        wb_ALURes,
  output logic [31:0]        wb_load_data,
  output logic [4:0]         wb_rd,
  output logic               wb_RegWEn,
  output logic               wb_is_load,
  output logic               m_fault
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] m_B_data;
  logic        m_MemRd, m_MemWr;
  logic [2:0]  m_funct3;

  logic        mem_op, is_byte, is_half, is_word, misaligned, timeout, complete;
  logic [1:0]  off;
  logic [3:0]  strb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_ALURes <= '0;
      m_B_data <= '0;
      m_MemRd  <= 1'b0;
      m_MemWr  <= 1'b0;
      m_funct3 <= '0;
      m_rd     <= '0;
      m_RegWEn <= 1'b0;
    end else if (!stall) begin
      m_valid  <= e_valid;
      m_ALURes <= e_ALURes;
      m_B_data <= e_B_bypass_data;
      m_MemRd  <= e_MemRd;
      m_MemWr  <= e_MemWr;
      m_funct3 <= e_funct3;
      m_rd     <= e_rd;
      m_RegWEn <= e_RegWEn;
    end
  end

  assign mem_op  = m_valid & (m_MemRd | m_MemWr);
  assign is_byte = (m_funct3[1:0] == 2'b00);
  assign is_half = (m_funct3[1:0] == 2'b01);
  assign is_word = m_funct3[1];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (is_half & m_ALURes[0]) | (is_word & (m_ALURes[1:0] != 2'b00));
  assign off        = m_ALURes[1:0];
`else
  // No trap: silently snap the offset to the access's natural alignment.
  assign misaligned = 1'b0;
  assign off        = is_word ? 2'b00 : (is_half ? {m_ALURes[1], 1'b0} : m_ALURes[1:0]);
`endif

  assign timeout = (WAIT_MAX != 0) && (wait_cnt_q == WAIT_MAX);

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    dmem.dmem_req = 1'b0;
    complete      = 1'b0;
    m_fault       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          if (misaligned) begin
            complete = 1'b1;
            m_fault  = 1'b1;
          end else begin
            dmem.dmem_req = 1'b1;
            if (dmem.dmem_ack) begin
              complete = 1'b1;
            end else begin
              state_d    = StWait;
              wait_cnt_d = 32'd1;
            end
          end
        end
      end
      StWait: begin
        dmem.dmem_req = ~timeout;
        if (dmem.dmem_ack) begin
          complete   = 1'b1;
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (timeout) begin
          complete   = 1'b1;
          m_fault    = 1'b1;
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
    endcase
  end

  assign stall = mem_op & ~complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    strb = 4'b1111;
    if (is_byte) begin
      strb = 4'b0001 << off;
    end else if (is_half) begin
      strb = 4'b0011 << off;
    end
  end

  assign dmem.dmem_we    = m_MemWr;
  assign dmem.dmem_addr  = {m_ALURes[ADDR_W-1:2], 2'b00};
  assign dmem.dmem_wstrb = m_MemWr ? strb : 4'b0000;
  assign dmem.dmem_wdata = is_byte ? {4{m_B_data[7:0]}} :
                           (is_half ? {2{m_B_data[15:0]}} : m_B_data);

  assign rd_byte  = dmem.dmem_rdata[{off, 3'b000} +: 8];
  assign rd_half  = dmem.dmem_rdata[{off[1], 4'b0000} +: 16];
  assign load_fmt = is_byte ? {{24{~m_funct3[2] & rd_byte[7]}}, rd_byte} :
                    (is_half ? {{16{~m_funct3[2] & rd_half[15]}}, rd_half} : dmem.dmem_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid     <= 1'b0;
      wb_ALURes    <= '0;
      wb_load_data <= '0;
      wb_rd        <= '0;
      wb_RegWEn    <= 1'b0;
      wb_is_load   <= 1'b0;
    end else if (!stall) begin
      wb_valid     <= m_valid;
      wb_ALURes    <= m_ALURes;
      wb_load_data <= m_MemRd ? load_fmt : 32'd0;
      wb_rd        <= m_rd;
      wb_RegWEn    <= m_RegWEn & ~m_fault;
      wb_is_load   <= m_MemRd;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage with a bench-side memory responder.
module tb_mem_access_stage;

  localparam int unsigned WaitMax = 4;
  localparam int          Never   = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_valid = 1'b0, e_MemRd = 1'b0, e_MemWr = 1'b0, e_RegWEn = 1'b0;
  logic [31:0] e_ALURes = '0, e_B_bypass_data = '0;
  logic [2:0]  e_funct3 = '0;
  logic [4:0]  e_rd = '0;
  logic        stall, m_valid, m_RegWEn, m_fault;
  logic [31:0] m_ALURes, wb_ALURes, wb_load_data;
  logic [4:0]  m_rd, wb_rd;
  logic        wb_valid, wb_RegWEn, wb_is_load;

  mem_access_stage_if #(.ADDR_W(32)) dmem ();

  mem_access_stage #(.ADDR_W(32), .WAIT_MAX(WaitMax)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_ALURes(e_ALURes),
    .e_B_bypass_data(e_B_bypass_data), .e_MemRd(e_MemRd), .e_MemWr(e_MemWr),
    .e_funct3(e_funct3), .e_rd(e_rd), .e_RegWEn(e_RegWEn), .stall(stall),
    .m_valid(m_valid), .m_ALURes(m_ALURes), .m_rd(m_rd), .m_RegWEn(m_RegWEn),
    .dmem(dmem), .wb_valid(wb_valid), .wb_ALURes(wb_ALURes), .wb_load_data(wb_load_data),
    .wb_rd(wb_rd), .wb_RegWEn(wb_RegWEn), .wb_is_load(wb_is_load), .m_fault(m_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] ld;
    logic [4:0]  rd;
    logic        regwen;
    logic        is_load;
    logic        fault;
    logic        chk_ld;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  wstrb;
    int          delay;
  } req_t;

  exp_t        exp_q[$];
  req_t        req_q[$];
  logic [31:0] ref_mem[int unsigned];
  logic [31:0] bus_mem[int unsigned];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] bus_rd(input int unsigned a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  // Architectural expectation of one instruction, applied in program order.
  function automatic void predict(input logic [31:0] alu, input logic [31:0] b, input logic rdn,
                                  input logic wrn, input logic [2:0] f3, input logic [4:0] rd,
                                  input logic regwen, input int delay, output exp_t e,
                                  output req_t q, output bit has_req);
    int          nb, off;
    bit          trap, tmo;
    logic [31:0] w, v;
    nb  = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    off = int'(alu[1:0]);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (off % nb) != 0;
`else
    off = off - (off % nb);
`endif
    e = '{alu: alu, ld: 32'd0, rd: rd, regwen: 1'b0, is_load: rdn, fault: 1'b0, chk_ld: 1'b1};
    q = '{addr: {alu[31:2], 2'b00}, wdata: 32'd0, we: wrn, wstrb: 4'd0, delay: delay};
    has_req = 1'b0;
    if (rdn || wrn) begin
      if (trap) begin
        e.fault = 1'b1;
      end else begin
        has_req = 1'b1;
        tmo = delay > int'(WaitMax);
        w = ref_rd(int'(alu[31:2]));
        if (wrn) begin
          for (int i = 0; i < nb; i++) q.wstrb[off + i] = 1'b1;
          for (int j = 0; j < 4; j++) q.wdata[8*j +: 8] = b[8*(j % nb) +: 8];
          if (!tmo) begin
            for (int i = 0; i < nb; i++) w[8*(off + i) +: 8] = b[8*i +: 8];
            ref_mem[int'(alu[31:2])] = w;
          end
        end
        if (tmo) begin
          e.fault = 1'b1;
        end else if (rdn) begin
          v = w >> (8 * off);
          if (nb == 1)      e.ld = f3[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
          else if (nb == 2) e.ld = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
          else              e.ld = w;
        end
      end
    end
    if (rdn && e.fault) e.chk_ld = 1'b0;
    e.regwen = regwen & ~e.fault;
  endfunction

  task automatic issue(input logic [31:0] alu, input logic [31:0] b, input logic rdn,
                       input logic wrn, input logic [2:0] f3, input logic [4:0] rd,
                       input logic regwen, input int delay, output int waits);
    exp_t e;
    req_t q;
    bit   has_req, captured;
    @(negedge clk);
    e_valid = 1'b1; e_ALURes = alu; e_B_bypass_data = b; e_MemRd = rdn; e_MemWr = wrn;
    e_funct3 = f3; e_rd = rd; e_RegWEn = regwen;
    waits = 0;
    captured = 1'b0;
    while (!captured) begin
      #4;
      captured = !stall;
      @(posedge clk);
      if (!captured) begin
        waits++;
        if (waits > 64) begin
          n_fail++;
          $display("FAIL issue_wait: stall held %0d cycles, expected at most 64", waits);
          $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
          $fatal(1);
        end
        @(negedge clk);
      end
    end
    predict(alu, b, rdn, wrn, f3, rd, regwen, delay, e, q, has_req);
    exp_q.push_back(e);
    if (has_req) req_q.push_back(q);
    #1;
    e_valid = 1'b0; e_MemRd = 1'b0; e_MemWr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e_valid = 1'b0; e_MemRd = 1'($urandom % 2); e_MemWr = 1'($urandom % 2);
      e_ALURes = $urandom;
      #4;
      @(posedge clk);
      #1;
      e_MemRd = 1'b0; e_MemWr = 1'b0;
    end
  endtask

  // Memory responder: acks a request after the delay chosen when it was issued.
  initial begin : responder
    bit   busy;
    int   cnt;
    req_t cur;
    logic [31:0] w;
    busy = 1'b0;
    cnt = 0;
    cur = '{addr: 32'd0, wdata: 32'd0, we: 1'b0, wstrb: 4'd0, delay: 0};
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (busy && dmem.dmem_ack) busy = 1'b0;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = $urandom;
      if (busy && !dmem.dmem_req) begin
        busy = 1'b0;
      end else if (busy) begin
        cnt++;
      end else if (dmem.dmem_req && rst_n) begin
        busy = 1'b1;
        cnt = 0;
        if (req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: got request at 0x%08h, expected none", dmem.dmem_addr);
          cur = '{addr: dmem.dmem_addr, wdata: 32'd0, we: 1'b0, wstrb: 4'd0, delay: 0};
        end else begin
          cur = req_q.pop_front();
          check("req_addr", dmem.dmem_addr, cur.addr);
          check("req_we", 32'(dmem.dmem_we), 32'(cur.we));
          check("req_wstrb", 32'(dmem.dmem_wstrb), 32'(cur.wstrb));
          if (cur.we) check("req_wdata", dmem.dmem_wdata, cur.wdata);
        end
      end
      if (busy && cnt == cur.delay) begin
        w = bus_rd(int'(dmem.dmem_addr[31:2]));
        dmem.dmem_ack = 1'b1;
        dmem.dmem_rdata = w;
        if (dmem.dmem_we) begin
          for (int l = 0; l < 4; l++)
            if (dmem.dmem_wstrb[l]) w[8*l +: 8] = dmem.dmem_wdata[8*l +: 8];
          bus_mem[int'(dmem.dmem_addr[31:2])] = w;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    logic fault_prev;
    fault_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && wb_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wb_unexpected: got wb_valid with rd %0d, expected none", wb_rd);
        end else begin
          e = exp_q.pop_front();
          check("wb_ALURes", wb_ALURes, e.alu);
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
          check("wb_RegWEn", 32'(wb_RegWEn), 32'(e.regwen));
          check("wb_is_load", 32'(wb_is_load), 32'(e.is_load));
          check("m_fault", 32'(fault_prev), 32'(e.fault));
          if (e.chk_ld) check("wb_load_data", wb_load_data, e.ld);
        end
      end
      #4;
      fault_prev = m_fault;
    end
  end

  initial begin : main
    int   w, cnt, kind, t, dly;
    logic [2:0] f3;
    logic [31:0] addr;
    logic [2:0] ld_f3[5];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem.dmem_req), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_m_fault", 32'(m_fault), 32'd0);
    check("rst_m_ALURes", m_ALURes, 32'd0);
    check("rst_wb_RegWEn", 32'(wb_RegWEn), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ref_mem[32'h2000 >> 2] = 32'h1234_F678;
    bus_mem[32'h2000 >> 2] = 32'h1234_F678;
    ref_mem[32'h3000 >> 2] = 32'hCAFE_BABE;
    bus_mem[32'h3000 >> 2] = 32'hCAFE_BABE;

    issue(32'h1003, 32'hAABB_CCDD, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0, 0, w);
    @(negedge clk);
    #4;
    check("sb_stall", 32'(stall), 32'd0);
    check("sb_addr", dmem.dmem_addr, 32'h1000);
    check("sb_wstrb", 32'(dmem.dmem_wstrb), 32'b1000);
    check("sb_wdata", dmem.dmem_wdata, 32'hDDDD_DDDD);

    issue(32'h2001, 32'd0, 1'b1, 1'b0, 3'b000, 5'd5, 1'b1, 3, w);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      if (!stall) break;
      cnt++;
    end
    check("lb_stall_cycles", 32'(cnt), 32'd3);
    check("lb_bubble", 32'(wb_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lb_wb_data", wb_load_data, 32'hFFFF_FFF6);

    issue(32'h2001, 32'd0, 1'b1, 1'b0, 3'b100, 5'd6, 1'b1, 0, w);
    @(posedge clk);
    #1;
    check("lbu_wb_data", wb_load_data, 32'h0000_00F6);

    issue(32'h55, 32'd0, 1'b0, 1'b0, 3'b000, 5'd7, 1'b1, 0, w);
    check("add_m_ALURes", m_ALURes, 32'h55);
    issue(32'h2000, 32'd0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1, 1, w);
    check("add_no_stall", 32'(w), 32'd0);

    issue(32'h2004, 32'd0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, Never, w);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #4;
      if (!dmem.dmem_req) break;
      cnt++;
    end
    check("tmo_req_cycles", 32'(cnt), 32'(WaitMax));
    check("tmo_fault", 32'(m_fault), 32'd1);
    check("tmo_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("tmo_wb_RegWEn", 32'(wb_RegWEn), 32'd0);
    check("tmo_wb_valid", 32'(wb_valid), 32'd1);

    issue(32'h3002, 32'd0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 1, w);
    @(negedge clk);
    #4;
`ifdef MISALIGN_TRAP_EN
    check("mis_no_req", 32'(dmem.dmem_req), 32'd0);
    check("mis_fault", 32'(m_fault), 32'd1);
`else
    check("mis_req", 32'(dmem.dmem_req), 32'd1);
    check("mis_addr", dmem.dmem_addr, 32'h3000);
`endif

    for (int n = 0; n < 250; n++) begin
      if ($urandom % 10 < 2) idle(1);
      kind = $urandom % 3;
      t = $urandom % 10;
      dly = (t < 4) ? t : ((t < 8) ? int'($urandom % 2) : Never);
      addr = 32'h100 + ($urandom % 64);
      if (kind == 0) begin
        issue($urandom, $urandom, 1'b0, 1'b0, 3'($urandom), 5'($urandom), 1'($urandom), 0, w);
      end else if (kind == 1) begin
        f3 = ld_f3[$urandom % 5];
        issue(addr, $urandom, 1'b1, 1'b0, f3, 5'($urandom), 1'b1, dly, w);
      end else begin
        f3 = 3'($urandom % 3);
        issue(addr, $urandom, 1'b0, 1'b1, f3, 5'($urandom), 1'($urandom), dly, w);
      end
    end

    idle(12);
    check("drain_wb_queue", 32'(exp_q.size()), 32'd0);
    check("drain_req_queue", 32'(req_q.size()), 32'd0);

    issue(32'h2008, 32'd0, 1'b1, 1'b0, 3'b010, 5'd11, 1'b1, Never, w);
    repeat (2) @(negedge clk);
    #4;
    check("midwait_req_before", 32'(dmem.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midwait_rst_req", 32'(dmem.dmem_req), 32'd0);
    check("midwait_rst_stall", 32'(stall), 32'd0);
    check("midwait_rst_m_valid", 32'(m_valid), 32'd0);
    check("midwait_rst_wb_valid", 32'(wb_valid), 32'd0);
    exp_q.delete();
    req_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(32'h77, 32'd0, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1, 0, w);
    idle(4);
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
